video_timing_prog: RTL and testbench

Programmable raster timing generator. It produces sync, blank, data-enable, pixel coordinates and frame/line event pulses for a display pipeline, and sits between the pixel clock domain and the scan-out/framebuffer reader. Timing is loaded from parameter defaults at reset. It can be reprogrammed at run time through a shadow register bank, which is committed only at a frame boundary so a mode change never produces a torn frame. All outputs come from a parametrised-depth register pipeline, so downstream pixel fetch latency can be matched.

---
 rtl/video_timing_prog_if.sv | 24 ++
 rtl/video_timing_prog.sv | 198 +++++++++++++++++++
 tb/tb_video_timing_prog.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_prog_if.sv
// Configuration bus for the programmable raster timing generator.
// The host side drives shadow-register writes and observes the pending flag.
interface video_timing_prog_if #(
  parameter int COORD_WIDTH = 11
);
  logic                   i_cfg_wr;
  logic [3:0]             i_cfg_addr;
  logic [COORD_WIDTH-1:0] i_cfg_wdata;
  logic                   o_cfg_pending;

  modport master (
    output i_cfg_wr,
    output i_cfg_addr,
    output i_cfg_wdata,
    input  o_cfg_pending
  );

  modport slave (
    input  i_cfg_wr,
    input  i_cfg_addr,
    input  i_cfg_wdata,
    output o_cfg_pending
  );
endinterface

// File: rtl/video_timing_prog.sv
// Programmable raster timing generator. A shadow bank takes run-time writes
// and is copied into the active bank only at the end of a frame (or on every
// edge while disabled), so a mode change never tears a frame. All raster
// outputs travel through PIPE_DELAY register stages to match fetch latency.
module video_timing_prog #(
  parameter int COORD_WIDTH = 11,
  parameter int PIPE_DELAY  = 2,
  parameter int HLINE       = 640,
  parameter int HBACK       = 48,
  parameter int HFRONT      = 16,
  parameter int HPULSE      = 96,
  parameter int VLINE       = 480,
  parameter int VBACK       = 33,
  parameter int VFRONT      = 10,
  parameter int VPULSE      = 2,
  parameter bit HSPOL       = 1'b0,
  parameter bit VSPOL       = 1'b0
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_enable,
  video_timing_prog_if.slave     cfg,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_hblank,
  output logic                   o_vblank,
  output logic                   o_data_enable,
  output logic [COORD_WIDTH-1:0] o_pos_x,
  output logic [COORD_WIDTH-1:0] o_pos_y,
  output logic                   o_line_start,
  output logic                   o_frame_start,
  output logic                   o_vblank_start
);

  localparam int W = COORD_WIDTH;
  localparam logic [W-1:0] ONE = W'(1);

  typedef struct packed {
    logic [W-1:0] hline;
    logic [W-1:0] hback;
    logic [W-1:0] hfront;
    logic [W-1:0] hpulse;
    logic [W-1:0] vline;
    logic [W-1:0] vback;
    logic [W-1:0] vfront;
    logic [W-1:0] vpulse;
    logic         hspol;
    logic         vspol;
  } timing_t;

  typedef struct packed {
    logic         hsync;
    logic         vsync;
    logic         hblank;
    logic         vblank;
    logic         de;
    logic [W-1:0] pos_x;
    logic [W-1:0] pos_y;
    logic         line_start;
    logic         frame_start;
    logic         vblank_start;
  } raster_t;

  localparam timing_t TIMING_RST = '{
    hline:  W'(HLINE),  hback:  W'(HBACK),  hfront: W'(HFRONT), hpulse: W'(HPULSE),
    vline:  W'(VLINE),  vback:  W'(VBACK),  vfront: W'(VFRONT), vpulse: W'(VPULSE),
    hspol:  HSPOL,      vspol:  VSPOL
  };

  localparam raster_t IDLE_RST = '{
    hsync: ~HSPOL, vsync: ~VSPOL, hblank: 1'b1, vblank: 1'b1, de: 1'b0,
    pos_x: '0, pos_y: '0, line_start: 1'b0, frame_start: 1'b0, vblank_start: 1'b0
  };

  timing_t      shadow;
  timing_t      active;
  logic         pending;
  logic [W-1:0] h;
  logic [W-1:0] v;

  logic [W-1:0] htotal;
  logic [W-1:0] vtotal;
  logic [W-1:0] h_act_start;
  logic [W-1:0] h_act_end;
  logic [W-1:0] v_act_start;
  logic [W-1:0] v_act_end;
  logic         h_last;
  logic         v_last;
  logic         commit;

  raster_t      raster_p0;
  raster_t      pipe_p [1:PIPE_DELAY];

  // Raster geometry derived from the active bank, in counter-width arithmetic.
  always_comb begin
    h_act_start = active.hpulse + active.hback;
    h_act_end   = h_act_start + active.hline;
    htotal      = h_act_end + active.hfront;
    v_act_start = active.vpulse + active.vback;
    v_act_end   = v_act_start + active.vline;
    vtotal      = v_act_end + active.vfront;
    h_last      = (h == htotal - ONE);
    v_last      = (v == vtotal - ONE);
    commit      = ~i_enable | (h_last & v_last);
  end

  // Pixel and line counters; held at the origin while disabled.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      h <= '0;
      v <= '0;
    end else if (!i_enable) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + ONE;
    end else begin
      h <= h + ONE;
    end
  end

  // Shadow/active banks: the commit copies the pre-write shadow, so a write
  // landing on the commit edge stays pending for the following frame.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shadow  <= TIMING_RST;
      active  <= TIMING_RST;
      pending <= 1'b0;
    end else begin
      if (commit) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      if (cfg.i_cfg_wr && (cfg.i_cfg_addr <= 4'd8)) begin
        pending <= 1'b1;
        case (cfg.i_cfg_addr)
          4'd0:    shadow.hline  <= cfg.i_cfg_wdata;
          4'd1:    shadow.hback  <= cfg.i_cfg_wdata;
          4'd2:    shadow.hfront <= cfg.i_cfg_wdata;
          4'd3:    shadow.hpulse <= cfg.i_cfg_wdata;
          4'd4:    shadow.vline  <= cfg.i_cfg_wdata;
          4'd5:    shadow.vback  <= cfg.i_cfg_wdata;
          4'd6:    shadow.vfront <= cfg.i_cfg_wdata;
          4'd7:    shadow.vpulse <= cfg.i_cfg_wdata;
          default: {shadow.vspol, shadow.hspol} <= cfg.i_cfg_wdata[1:0];
        endcase
      end
    end
  end

  assign cfg.o_cfg_pending = pending;

  // ---- stage 0: decode counters against the active bank ----
  // Raster decode; idle values at the programmed polarity while disabled.
  always_comb begin
    raster_p0              = '0;
    raster_p0.hsync        = ~active.hspol;
    raster_p0.vsync        = ~active.vspol;
    raster_p0.hblank       = 1'b1;
    raster_p0.vblank       = 1'b1;
    if (i_enable) begin
      raster_p0.hsync        = (h < active.hpulse) ? active.hspol : ~active.hspol;
      raster_p0.vsync        = (v < active.vpulse) ? active.vspol : ~active.vspol;
      raster_p0.hblank       = (h < h_act_start) || (h >= h_act_end);
      raster_p0.vblank       = (v < v_act_start) || (v >= v_act_end);
      raster_p0.de           = ~raster_p0.hblank & ~raster_p0.vblank;
      raster_p0.pos_x        = raster_p0.hblank ? '0 : h - h_act_start;
      raster_p0.pos_y        = raster_p0.vblank ? '0 : v - v_act_start;
      raster_p0.line_start   = (h == '0);
      raster_p0.frame_start  = (h == '0) && (v == '0);
      raster_p0.vblank_start = (h == '0) && (v == v_act_end);
    end
  end

  // ---- stages 1..PIPE_DELAY: output alignment pipeline ----
  // Shift register for the whole raster bundle; reset drains to idle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 1; i <= PIPE_DELAY; i++) pipe_p[i] <= IDLE_RST;
    end else begin
      pipe_p[1] <= raster_p0;
      for (int i = 2; i <= PIPE_DELAY; i++) pipe_p[i] <= pipe_p[i-1];
    end
  end

  assign o_hsync        = pipe_p[PIPE_DELAY].hsync;
  assign o_vsync        = pipe_p[PIPE_DELAY].vsync;
  assign o_hblank       = pipe_p[PIPE_DELAY].hblank;
  assign o_vblank       = pipe_p[PIPE_DELAY].vblank;
  assign o_data_enable  = pipe_p[PIPE_DELAY].de;
  assign o_pos_x        = pipe_p[PIPE_DELAY].pos_x;
  assign o_pos_y        = pipe_p[PIPE_DELAY].pos_y;
  assign o_line_start   = pipe_p[PIPE_DELAY].line_start;
  assign o_frame_start  = pipe_p[PIPE_DELAY].frame_start;
  assign o_vblank_start = pipe_p[PIPE_DELAY].vblank_start;

endmodule

// File: tb/tb_video_timing_prog.sv
// Bench for video_timing_prog with reduced timing (HTOTAL=8, VTOTAL=6) and
// PIPE_DELAY=3. Stimulus queues cycle-stamped expectations; a monitor on the
// falling edge compares whatever is due in that cycle.
module tb_video_timing_prog;
  localparam int W  = 11;
  localparam int PD = 3;

  localparam int S_HS = 0, S_VS = 1, S_HB = 2, S_VB = 3, S_DE = 4, S_PX = 5, S_PY = 6;
  localparam int S_LS = 7, S_FS = 8, S_VBS = 9, S_PEND = 10;
  localparam int S_DECNT = 11, S_HSLOW = 12, S_LSCNT = 13;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         hsync, vsync, hblank, vblank, de;
  logic [W-1:0] pos_x, pos_y;
  logic         line_start, frame_start, vblank_start;

  video_timing_prog_if #(.COORD_WIDTH(W)) cfg_bus ();

  video_timing_prog #(
    .COORD_WIDTH(W), .PIPE_DELAY(PD),
    .HLINE(4), .HBACK(2), .HFRONT(1), .HPULSE(1),
    .VLINE(3), .VBACK(1), .VFRONT(1), .VPULSE(1),
    .HSPOL(1'b0), .VSPOL(1'b0)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .cfg(cfg_bus),
    .o_hsync(hsync), .o_vsync(vsync), .o_hblank(hblank), .o_vblank(vblank),
    .o_data_enable(de), .o_pos_x(pos_x), .o_pos_y(pos_y),
    .o_line_start(line_start), .o_frame_start(frame_start),
    .o_vblank_start(vblank_start)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    at;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   de_cnt = 0;
  int   hs_low = 0;
  int   ls_cnt = 0;

  task automatic expect_at(input int at, input int sig, input int val, input string name);
    exp_t e;
    e.at = at; e.sig = sig; e.val = val; e.name = name;
    exp_q.push_back(e);
  endtask

  function automatic int sample(input int sig);
    case (sig)
      S_HS:    return int'(hsync);
      S_VS:    return int'(vsync);
      S_HB:    return int'(hblank);
      S_VB:    return int'(vblank);
      S_DE:    return int'(de);
      S_PX:    return int'(pos_x);
      S_PY:    return int'(pos_y);
      S_LS:    return int'(line_start);
      S_FS:    return int'(frame_start);
      S_VBS:   return int'(vblank_start);
      S_PEND:  return int'(cfg_bus.o_cfg_pending);
      S_DECNT: return de_cnt;
      S_HSLOW: return hs_low;
      S_LSCNT: return ls_cnt;
      default: return -1;
    endcase
  endfunction

  // Monitor: per-frame counters restart on each frame_start, then due entries are checked.
  initial begin
    forever begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        de_cnt = 0; hs_low = 0; ls_cnt = 0;
      end
      if (de === 1'b1) de_cnt++;
      if (hsync === 1'b0) hs_low++;
      if (line_start === 1'b1) ls_cnt++;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].at <= cyc) begin
          checks++;
          if (exp_q[i].at < cyc) begin
            errors++;
            $display("FAIL %s: due at cycle %0d, not evaluated (now %0d)", exp_q[i].name, exp_q[i].at, cyc);
          end else if (sample(exp_q[i].sig) != exp_q[i].val) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                     exp_q[i].name, cyc, sample(exp_q[i].sig), exp_q[i].val);
          end
          exp_q.delete(i);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic cfg_write(input int at, input logic [3:0] addr, input logic [W-1:0] data);
    wait_cyc(at);
    cfg_bus.i_cfg_wr    = 1'b1;
    cfg_bus.i_cfg_addr  = addr;
    cfg_bus.i_cfg_wdata = data;
  endtask

  task automatic cfg_idle(input int at);
    wait_cyc(at);
    cfg_bus.i_cfg_wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    cfg_bus.i_cfg_wr    = 1'b0;
    cfg_bus.i_cfg_addr  = 4'd0;
    cfg_bus.i_cfg_wdata = '0;

    // Reset state (cycle 2): idle, sync at inactive level of default polarity 0.
    expect_at(2, S_HS, 1, "rst_hsync");   expect_at(2, S_VS, 1, "rst_vsync");
    expect_at(2, S_HB, 1, "rst_hblank");  expect_at(2, S_VB, 1, "rst_vblank");
    expect_at(2, S_DE, 0, "rst_de");      expect_at(2, S_FS, 0, "rst_frame_start");
    expect_at(2, S_PX, 0, "rst_pos_x");   expect_at(2, S_PEND, 0, "rst_pending");

    // Enable at cycle 8: frame 0 pixel (h,v) appears at 11 + 8v + h.
    expect_at(10, S_FS, 0, "en_fs_early"); expect_at(10, S_HS, 1, "en_idle_hsync");
    expect_at(11, S_FS, 1, "f0_fs");   expect_at(11, S_LS, 1, "f0_ls");
    expect_at(11, S_HS, 0, "f0_hs");   expect_at(11, S_VS, 0, "f0_vs");
    expect_at(11, S_HB, 1, "f0_hb");   expect_at(11, S_VB, 1, "f0_vb");
    expect_at(12, S_HS, 1, "f0_hs_h1"); expect_at(12, S_FS, 0, "f0_fs_h1");
    expect_at(12, S_LS, 0, "f0_ls_h1");
    expect_at(19, S_LS, 1, "f0_ls_v1"); expect_at(19, S_VS, 1, "f0_vs_v1");
    expect_at(19, S_FS, 0, "f0_fs_v1");
    expect_at(30, S_DE, 1, "f0_de_3_2"); expect_at(30, S_PX, 0, "f0_px_3_2");
    expect_at(30, S_PY, 0, "f0_py_3_2"); expect_at(30, S_HB, 0, "f0_hb_3_2");
    expect_at(30, S_VB, 0, "f0_vb_3_2");
    expect_at(49, S_DE, 1, "f0_de_6_4"); expect_at(49, S_PX, 3, "f0_px_6_4");
    expect_at(49, S_PY, 2, "f0_py_6_4");
    expect_at(50, S_DE, 0, "f0_de_7_4"); expect_at(50, S_HB, 1, "f0_hb_7_4");
    expect_at(50, S_PX, 0, "f0_px_7_4"); expect_at(50, S_PY, 2, "f0_py_7_4");
    expect_at(51, S_VBS, 1, "f0_vbs_0_5"); expect_at(51, S_VB, 1, "f0_vb_0_5");
    expect_at(51, S_PY, 0, "f0_py_0_5");
    expect_at(52, S_VBS, 0, "f0_vbs_1_5");
    expect_at(58, S_DECNT, 12, "f0_de_count"); expect_at(58, S_HSLOW, 6, "f0_hsync_low");
    expect_at(58, S_LSCNT, 6, "f0_line_count");
    expect_at(59, S_FS, 1, "f1_fs");

    // HLINE=6 written at cycle 76; frame 1 keeps HTOTAL=8, frame 2 (from 107) uses 10.
    expect_at(76, S_PEND, 0, "wr_pend_before"); expect_at(77, S_PEND, 1, "wr_pend_set");
    expect_at(99, S_LS, 1, "f1_ls_v5");
    expect_at(103, S_PEND, 1, "wr_pend_hold"); expect_at(104, S_PEND, 0, "wr_pend_commit");
    expect_at(106, S_LS, 0, "f1_ls_h7"); expect_at(106, S_HB, 1, "f1_hb_h7");
    expect_at(106, S_DECNT, 12, "f1_de_count");
    expect_at(107, S_FS, 1, "f2_fs");
    expect_at(115, S_LS, 0, "f2_ls_h8"); expect_at(115, S_HB, 0, "f2_hb_h8");
    expect_at(115, S_PX, 5, "f2_px_h8"); expect_at(115, S_DE, 0, "f2_de_v0");
    expect_at(117, S_LS, 1, "f2_ls_v1");
    expect_at(135, S_DE, 1, "f2_de_8_2"); expect_at(135, S_PX, 5, "f2_px_8_2");
    expect_at(135, S_PY, 0, "f2_py_8_2");
    expect_at(166, S_DECNT, 18, "f2_de_count"); expect_at(166, S_HSLOW, 6, "f2_hsync_low");

    // Polarity=3 written on the frame-2 commit edge: frame 3 keeps polarity 0.
    expect_at(164, S_PEND, 1, "pol_pend_set");
    expect_at(167, S_FS, 1, "f3_fs"); expect_at(167, S_HS, 0, "f3_hs_oldpol");
    expect_at(167, S_VS, 0, "f3_vs_oldpol");
    expect_at(223, S_PEND, 1, "pol_pend_hold"); expect_at(224, S_PEND, 0, "pol_pend_commit");
    expect_at(227, S_FS, 1, "f4_fs"); expect_at(227, S_HS, 1, "f4_hs_newpol");
    expect_at(227, S_VS, 1, "f4_vs_newpol");
    expect_at(228, S_HS, 0, "f4_hs_h1"); expect_at(228, S_VS, 1, "f4_vs_h1");
    expect_at(237, S_VS, 0, "f4_vs_v1"); expect_at(237, S_LS, 1, "f4_ls_v1");

    // Disable at cycle 249; last live pixel (4,2) at 251, idle from 252.
    expect_at(251, S_DE, 1, "dis_de_last"); expect_at(251, S_PX, 1, "dis_px_last");
    expect_at(251, S_PY, 0, "dis_py_last");
    expect_at(252, S_DE, 0, "dis_de_idle"); expect_at(252, S_HB, 1, "dis_hb_idle");
    expect_at(252, S_VB, 1, "dis_vb_idle"); expect_at(252, S_HS, 0, "dis_hs_idle_pos");
    expect_at(252, S_VS, 0, "dis_vs_idle_pos"); expect_at(252, S_PX, 0, "dis_px_idle");
    expect_at(252, S_FS, 0, "dis_fs_idle");
    expect_at(253, S_PEND, 0, "dis_pend_before"); expect_at(254, S_PEND, 1, "dis_pend_set");
    expect_at(255, S_PEND, 1, "dis_pend_rewrite"); expect_at(256, S_PEND, 0, "dis_pend_commit");
    expect_at(257, S_HS, 0, "dis_hs_oldpol"); expect_at(258, S_HS, 1, "dis_hs_newpol");

    // Re-enable at 258 with HLINE=4, polarity 0: frame restarts at 261.
    expect_at(260, S_FS, 0, "ren_fs_early"); expect_at(260, S_DE, 0, "ren_de_early");
    expect_at(261, S_FS, 1, "ren_fs"); expect_at(261, S_HS, 0, "ren_hs");
    expect_at(268, S_LS, 0, "ren_ls_h7"); expect_at(268, S_HB, 1, "ren_hb_h7");
    expect_at(269, S_LS, 1, "ren_ls_v1");

    // Asynchronous reset pulse between edges after cycle 281, mid active line.
    expect_at(280, S_PEND, 1, "ar_pend_before"); expect_at(280, S_DE, 1, "ar_de_before");
    expect_at(280, S_PX, 0, "ar_px_before");
    expect_at(281, S_DE, 0, "ar_de"); expect_at(281, S_HB, 1, "ar_hb");
    expect_at(281, S_VB, 1, "ar_vb"); expect_at(281, S_HS, 1, "ar_hs");
    expect_at(281, S_VS, 1, "ar_vs"); expect_at(281, S_PX, 0, "ar_px");
    expect_at(281, S_PY, 0, "ar_py"); expect_at(281, S_LS, 0, "ar_ls");
    expect_at(281, S_PEND, 0, "ar_pend");
    expect_at(283, S_FS, 0, "ar_fs_early"); expect_at(283, S_DE, 0, "ar_de_early");
    expect_at(284, S_FS, 1, "ar_fs"); expect_at(284, S_LS, 1, "ar_ls_restart");
    expect_at(284, S_HS, 0, "ar_hs_restart");
    expect_at(292, S_LS, 1, "ar_ls_v1");

    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(8);
    en = 1'b1;
    cfg_write(76, 4'd0, W'(6));
    cfg_idle(77);
    cfg_write(163, 4'd8, W'(3));
    cfg_idle(164);
    wait_cyc(249);
    en = 1'b0;
    cfg_write(253, 4'd8, W'(0));
    cfg_write(254, 4'd0, W'(4));
    cfg_idle(255);
    wait_cyc(258);
    en = 1'b1;
    cfg_write(279, 4'd3, W'(1));
    cfg_idle(280);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;

    wait_cyc(300);
    @(posedge clk);
    #1;
    foreach (exp_q[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: due at cycle %0d, never evaluated", exp_q[i].name, exp_q[i].at);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
